ffsr_pulse_sched: RTL and testbench
===================================

Name: ffsr_pulse_sched

Overview:
- Sequencer/arbiter for one ffsr_pulse thermometer-coded potential register (the neuron body).
- Owns the register's rst/inc/dec/init pins.
- Shares the register between NUM_REQ synapse requesters by round-robin, one unit step per cycle.
- Detects threshold crossing, emits a spike, enforces a refractory period, then reloads the initial potential.

Parameters:
- WIDTH, 8: width of the ffsr_pulse register and init value; must be >1.
- NUM_REQ, 4: number of requesters; must be >=1.
- THRESH, 6: fire when ffsr_out[THRESH-1]==1; range 1..WIDTH.
- REFRACT_CYCLES, 4: cycles spent in REFRACT; must be >=1.
- LEAK_PERIOD, 16: leak interval in cycles; used only with FFSR_LEAK_EN; must be >=2.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- en  in  1  level; start/continue operation.
- init_val  in  WIDTH  thermometer-coded initial potential, sampled in LOAD.
- req_inc  in  NUM_REQ  per-requester increment request, level, held until granted.
- req_dec  in  NUM_REQ  per-requester decrement request, level, held until granted.
- grant  out  NUM_REQ  one-hot grant pulse, combinational.
- ffsr_rst  out  1  drives ffsr_pulse rst.
- ffsr_inc  out  1  drives ffsr_pulse inc.
- ffsr_dec  out  1  drives ffsr_pulse dec.
- ffsr_init  out  WIDTH  drives ffsr_pulse init.
- ffsr_out  in  WIDTH  current ffsr_pulse value.
- spike  out  1  one-cycle fire pulse.
- sat  out  1  one-cycle pulse: granted step dropped at a bound.
- busy  out  1  high in every state except IDLE.

Behaviour:
- States: IDLE, LOAD, RUN, FIRE, REFRACT. Reset (including mid-operation) forces IDLE.
- All registered state is cleared on reset: refractory counter 0, rr pointer 0, leak counter 0.
- ffsr_init = init_val at all times.
- ffsr_rst = 1 in IDLE and LOAD, else 0.
- ffsr_inc and ffsr_dec are never both 1; they are 0 outside RUN.
- IDLE: no grants. en=1 -> LOAD.
- LOAD: one cycle. ffsr_rst=1. Rr pointer is kept. -> RUN if en=1, else IDLE.
- RUN:
  - en=0 -> IDLE; no grant that cycle.
  - Else if ffsr_out[THRESH-1]==1 -> FIRE; no grant that cycle.
  - Else arbitrate.
- Arbitration:
  - Candidate i is any requester with req_inc[i] | req_dec[i].
  - Winner is the first candidate at or after the rr pointer, wrapping modulo NUM_REQ.
  - grant[winner]=1 in the same cycle; the pointer is registered to winner+1 mod NUM_REQ.
- Operation for the winner:
  - inc only: ffsr_inc=1, unless ffsr_out[WIDTH-1]==1 -> suppress, sat=1.
  - dec only: ffsr_dec=1, unless ffsr_out[0]==0 -> suppress, sat=1.
  - both inc and dec: grant consumed, no operation, sat=0.
- Requester rule: a granted requester must deassert both reqs on the next cycle. A req still high after its grant is treated as a new request.
- Latency: a step issued in cycle t appears on ffsr_out at t+1. Threshold is checked on the current ffsr_out, so a crossing step fires one cycle after its grant.
- FIRE: one cycle, spike=1, no grants -> REFRACT with counter loaded to REFRACT_CYCLES-1.
- REFRACT:
  - No grants; pending reqs stay pending. Counter decrements.
  - At 0: -> LOAD if en=1, else IDLE.
  - The potential is not reset until LOAD.
- THRESH with init_val already at or above threshold: LOAD -> RUN -> FIRE immediately. This repeats each refractory cycle; it is legal and not flagged.
- No requests in RUN: hold the value (inc=dec=0).

Optional Feature:
- Macro: FFSR_LEAK_EN.
- Defined:
  - The leak counter increments every RUN cycle and clears in LOAD.
  - When it reaches LEAK_PERIOD-1, a leak is pending.
  - A pending leak issues ffsr_dec=1 in the first RUN cycle with no grant and no fire transition, then the counter clears.
  - Grants take priority over the leak.
  - A leak at ffsr_out[0]==0 is silently dropped (no sat).
- Undefined: no leak counter is built; the potential holds between grants.

Test Plan:
- Reset, init_val=8'b0000_0011, en=1 -> LOAD for 1 cycle with ffsr_rst=1, then RUN; ffsr_out=0x03; busy=1, spike=0.
- All 4 req_inc held continuously from 0x03 -> grants 0001, 0010, 0100, 1000 in consecutive cycles; ffsr_out 0x07, 0x0F, 0x1F, 0x3F; then FIRE with spike=1, 4 REFRACT cycles, LOAD; ffsr_out back to 0x03.
- req_dec[2] single pulse from 0x03 -> grant[2]=1, ffsr_out=0x01. Repeat twice -> 0x00 then sat=1 with ffsr_out staying 0x00.
- req_inc[1] and req_dec[1] both high -> grant[1]=1, ffsr_inc=ffsr_dec=0, sat=0, value unchanged.
- rst asserted in REFRACT with req_inc[0] pending -> next cycle IDLE, busy=0, ffsr_rst=1, grant=0, rr pointer 0.
- FFSR_LEAK_EN, LEAK_PERIOD=4, value 0x0F, no reqs -> ffsr_dec pulse every 4 RUN cycles: 0x07, 0x03, 0x01, 0x00. A req_inc in the leak cycle is granted first and the leak slips one cycle.

Source files
------------

// File: rtl/ffsr_pulse_sched.sv
// Round-robin step sequencer and fire/refractory controller for one ffsr_pulse potential register.
// Optional feature macro: FFSR_LEAK_EN (periodic leak decrement during RUN).
module ffsr_pulse_sched #(
    parameter int WIDTH          = 8,
    parameter int NUM_REQ        = 4,
    parameter int THRESH         = 6,
    parameter int REFRACT_CYCLES = 4,
    parameter int LEAK_PERIOD    = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic [WIDTH-1:0]   init_val,
    input  logic [NUM_REQ-1:0] req_inc,
    input  logic [NUM_REQ-1:0] req_dec,
    output logic [NUM_REQ-1:0] grant,
    output logic               ffsr_rst,
    output logic               ffsr_inc,
    output logic               ffsr_dec,
    output logic [WIDTH-1:0]   ffsr_init,
    input  logic [WIDTH-1:0]   ffsr_out,
    output logic               spike,
    output logic               sat,
    output logic               busy
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = (REFRACT_CYCLES > 1) ? $clog2(REFRACT_CYCLES) : 1;

    if (WIDTH < 2 || NUM_REQ < 1 || THRESH < 1 || THRESH > WIDTH ||
        REFRACT_CYCLES < 1 || LEAK_PERIOD < 2) begin : g_param_err
        $error("ffsr_pulse_sched: illegal parameter combination");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_FIRE,
        S_REFRACT
    } state_t;

    state_t             state_q, state_d;
    logic [PTR_W-1:0]   rr_q, rr_d;
    logic [CNT_W-1:0]   ref_q, ref_d;

    logic [NUM_REQ-1:0] cand;
    logic [NUM_REQ-1:0] rot;
    logic [NUM_REQ-1:0] rot_hi_unused;
    logic [PTR_W-1:0]   win_off;
    logic [PTR_W:0]     win_sum;
    logic [PTR_W-1:0]   win_idx;
    logic [PTR_W:0]     nxt_sum;
    logic [PTR_W-1:0]   nxt_ptr;
    logic               win_found;
    logic               win_inc;
    logic               win_dec;
    logic               fire_now;
    logic               ffsr_unused;

    assign fire_now    = ffsr_out[THRESH-1];
    assign ffsr_init   = init_val;
    assign ffsr_rst    = (state_q == S_IDLE) || (state_q == S_LOAD);
    assign busy        = (state_q != S_IDLE);
    assign ffsr_unused = ^ffsr_out;

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_cand
            assign cand[gi] = req_inc[gi] | req_dec[gi];
        end
    endgenerate

    // Rotate candidates so bit 0 is the requester at the rr pointer.
    assign {rot_hi_unused, rot} = {cand, cand} >> rr_q;

    always_comb begin
        win_found = 1'b0;
        win_off   = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (rot[k]) begin
                win_found = 1'b1;
                win_off   = PTR_W'(k);
            end
        end
    end

    always_comb begin
        win_sum = {1'b0, rr_q} + {1'b0, win_off};
        if (win_sum >= (PTR_W+1)'(NUM_REQ)) begin
            win_sum = win_sum - (PTR_W+1)'(NUM_REQ);
        end
        win_idx = win_sum[PTR_W-1:0];
        nxt_sum = {1'b0, win_idx} + 1'b1;
        if (nxt_sum >= (PTR_W+1)'(NUM_REQ)) begin
            nxt_sum = '0;
        end
        nxt_ptr = nxt_sum[PTR_W-1:0];
    end

    assign win_inc = req_inc[win_idx];
    assign win_dec = req_dec[win_idx];

`ifdef FFSR_LEAK_EN
    localparam int LEAK_W = $clog2(LEAK_PERIOD);
    logic [LEAK_W-1:0] leak_q, leak_d;
    logic              leak_pend;
    assign leak_pend = (leak_q == LEAK_W'(LEAK_PERIOD - 1));
`endif

    always_comb begin
        state_d  = state_q;
        rr_d     = rr_q;
        ref_d    = ref_q;
        grant    = '0;
        ffsr_inc = 1'b0;
        ffsr_dec = 1'b0;
        spike    = 1'b0;
        sat      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (en) state_d = S_LOAD;
            end
            S_LOAD: begin
                state_d = en ? S_RUN : S_IDLE;
            end
            S_RUN: begin
                if (!en) begin
                    state_d = S_IDLE;
                end else if (fire_now) begin
                    state_d = S_FIRE;
                end else if (win_found) begin
                    grant[win_idx] = 1'b1;
                    rr_d           = nxt_ptr;
                    // A step that would overflow or underflow is dropped and flagged.
                    if (win_inc && !win_dec) begin
                        if (ffsr_out[WIDTH-1]) sat = 1'b1;
                        else                   ffsr_inc = 1'b1;
                    end else if (win_dec && !win_inc) begin
                        if (!ffsr_out[0]) sat = 1'b1;
                        else              ffsr_dec = 1'b1;
                    end
                end
            end
            S_FIRE: begin
                spike   = 1'b1;
                state_d = S_REFRACT;
                ref_d   = CNT_W'(REFRACT_CYCLES - 1);
            end
            S_REFRACT: begin
                if (ref_q == '0) begin
                    state_d = en ? S_LOAD : S_IDLE;
                end else begin
                    ref_d = ref_q - 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
`ifdef FFSR_LEAK_EN
        leak_d = leak_q;
        if (state_q == S_LOAD) begin
            leak_d = '0;
        end else if (state_q == S_RUN) begin
            if (!leak_pend) begin
                leak_d = leak_q + 1'b1;
            end else if (en && !fire_now && !win_found) begin
                // Leak waits for a free cycle; at empty potential it is silently lost.
                ffsr_dec = ffsr_out[0];
                leak_d   = '0;
            end
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            rr_q    <= '0;
            ref_q   <= '0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            ref_q   <= ref_d;
        end
    end

`ifdef FFSR_LEAK_EN
    always_ff @(posedge clk) begin
        if (rst) leak_q <= '0;
        else     leak_q <= leak_d;
    end
`endif

endmodule

// File: tb/tb_ffsr_pulse_sched.sv
// Directed bench for ffsr_pulse_sched with a behavioural ffsr_pulse register attached.
module tb_ffsr_pulse_sched;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic [7:0] init_val;
    logic [3:0] req_inc;
    logic [3:0] req_dec;
    logic [3:0] grant;
    logic       ffsr_rst;
    logic       ffsr_inc;
    logic       ffsr_dec;
    logic [7:0] ffsr_init;
    logic [7:0] ffsr_out = 8'h00;
    logic       spike;
    logic       sat;
    logic       busy;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    ffsr_pulse_sched #(
        .WIDTH(8), .NUM_REQ(4), .THRESH(6), .REFRACT_CYCLES(4), .LEAK_PERIOD(4)
    ) dut (
        .clk(clk), .rst(rst), .en(en), .init_val(init_val),
        .req_inc(req_inc), .req_dec(req_dec), .grant(grant),
        .ffsr_rst(ffsr_rst), .ffsr_inc(ffsr_inc), .ffsr_dec(ffsr_dec),
        .ffsr_init(ffsr_init), .ffsr_out(ffsr_out),
        .spike(spike), .sat(sat), .busy(busy)
    );

    // Thermometer register: inc shifts a 1 in from the bottom, dec shifts a 0 in from the top.
    always @(posedge clk) begin
        if (ffsr_rst)      ffsr_out <= ffsr_init;
        else if (ffsr_inc) ffsr_out <= {ffsr_out[6:0], 1'b1};
        else if (ffsr_dec) ffsr_out <= {1'b0, ffsr_out[7:1]};
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            $display("ok   %s = %0h", tag, got);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] exp_out [4];
        logic [7:0] dec_out [3];
        logic [7:0] lv;
        exp_out = '{8'h03, 8'h07, 8'h0F, 8'h1F};
        dec_out = '{8'h01, 8'h00, 8'h00};

        rst = 1'b1; en = 1'b0; init_val = 8'h03; req_inc = '0; req_dec = '0;
        step(); step();
        check("rst_busy", busy, 0);
        check("rst_ffsr_rst", ffsr_rst, 1);
        check("rst_grant", grant, 0);
        check("rst_spike", spike, 0);
        check("init_pass", ffsr_init, 8'h03);

`ifndef FFSR_LEAK_EN
        rst = 1'b0; en = 1'b1;
        step();
        check("load_rst", ffsr_rst, 1);
        check("load_busy", busy, 1);
        step();
        check("run_out", ffsr_out, 8'h03);
        check("run_rst", ffsr_rst, 0);
        check("run_spike", spike, 0);

        // All four increment requests held: rotate 0..3, then fire.
        req_inc = 4'hF; #1;
        for (int k = 0; k < 4; k++) begin
            check($sformatf("rr_grant%0d", k), grant, 32'(1 << k));
            check($sformatf("rr_inc%0d", k), ffsr_inc, 1);
            check($sformatf("rr_out%0d", k), ffsr_out, exp_out[k]);
            step();
        end
        check("thr_out", ffsr_out, 8'h3F);
        check("thr_grant", grant, 0);
        check("thr_inc", ffsr_inc, 0);
        step();
        req_inc = '0; #1;
        check("fire_spike", spike, 1);
        check("fire_grant", grant, 0);
        for (int k = 0; k < 4; k++) begin
            step();
            check($sformatf("refr_spike%0d", k), spike, 0);
            check($sformatf("refr_rst%0d", k), ffsr_rst, 0);
        end
        step();
        check("reload_rst", ffsr_rst, 1);
        step();
        check("reload_out", ffsr_out, 8'h03);

        // Single-requester decrements down to the empty bound.
        for (int r = 0; r < 3; r++) begin
            req_dec = 4'b0100; #1;
            check($sformatf("dec_grant%0d", r), grant, 4'b0100);
            check($sformatf("dec_dec%0d", r), ffsr_dec, (r < 2) ? 1 : 0);
            check($sformatf("dec_sat%0d", r), sat, (r == 2) ? 1 : 0);
            step();
            req_dec = '0; #1;
            check($sformatf("dec_out%0d", r), ffsr_out, dec_out[r]);
            step();
        end

        // Simultaneous inc and dec from one requester: consumed, no step.
        req_inc = 4'b0010; req_dec = 4'b0010; #1;
        check("both_grant", grant, 4'b0010);
        check("both_inc", ffsr_inc, 0);
        check("both_dec", ffsr_dec, 0);
        check("both_sat", sat, 0);
        step();
        req_inc = '0; req_dec = '0; #1;
        check("both_out", ffsr_out, 8'h00);
        step();

        // Pointer now at 2: requesters 1 and 3 -> 3 first, then 1.
        req_inc = 4'b1010; #1;
        check("wrap_grant_a", grant, 4'b1000);
        step();
        check("wrap_grant_b", grant, 4'b0010);
        step();
        req_inc = '0; #1;
        check("wrap_out", ffsr_out, 8'h03);
        step();

        // en low in RUN: no grant, back to IDLE.
        en = 1'b0; req_inc = 4'b0001; #1;
        check("endis_grant", grant, 0);
        check("endis_inc", ffsr_inc, 0);
        step();
        check("idle_busy", busy, 0);
        check("idle_rst", ffsr_rst, 1);
        init_val = 8'h3F; en = 1'b1; #1;
        check("idle_grant", grant, 0);
        step();
        check("load2_grant", grant, 0);
        step();
        check("hot_out", ffsr_out, 8'h3F);
        check("hot_grant", grant, 0);
        step();
        check("hot_spike", spike, 1);
        step();
        check("refr2_busy", busy, 1);
        check("refr2_grant", grant, 0);
        rst = 1'b1;
        step();
        check("mid_rst_busy", busy, 0);
        check("mid_rst_ffsr", ffsr_rst, 1);
        check("mid_rst_grant", grant, 0);
        rst = 1'b0; init_val = 8'h03; req_inc = 4'b1001;
        step();
        step();
        check("ptr_reset_grant", grant, 4'b0001);
        step();
        req_inc = '0;
`else
        rst = 1'b0; en = 1'b1; init_val = 8'h0F;
        step();
        step();
        lv = 8'h0F;
        for (int c = 1; c <= 16; c++) begin
            check($sformatf("leak_dec%0d", c), ffsr_dec, (c % 4 == 0) ? 1 : 0);
            check($sformatf("leak_out%0d", c), ffsr_out, lv);
            step();
            if (c % 4 == 0) lv = lv >> 1;
        end
        check("leak_out_empty", ffsr_out, 8'h00);
        step(); step();
        check("leak_pre_dec", ffsr_dec, 0);
        step();
        req_inc = 4'b0001; #1;
        check("leak_slip_grant", grant, 4'b0001);
        check("leak_slip_inc", ffsr_inc, 1);
        check("leak_slip_nodec", ffsr_dec, 0);
        step();
        req_inc = '0; #1;
        check("leak_slip_out", ffsr_out, 8'h01);
        check("leak_slip_dec", ffsr_dec, 1);
        step();
        check("leak_slip_final", ffsr_out, 8'h00);
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
